// File: rtl/bram_pkg.sv
// Shared constants and types for the simple-dual-port block RAM.
// Read-during-write mode encodings and the clear-sequencer state type.
package bram_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  typedef enum logic {
    CLR_IDLE,
    CLR_SWEEP
  } clr_state_e;

endpackage

// File: rtl/bram_sdp_core.sv
// Bare RAM array: one byte-enable write port and one registered read port.
// Same-address read/write resolution follows RDW_MODE.
module bram_sdp_core
  import bram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 8,
  parameter int BYTE_WIDTH    = 8,
  parameter int RDW_MODE      = RDW_WRITE_FIRST,
  localparam int NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH,
  localparam int DEPTH        = 2 ** ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [ADDRESS_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [NUM_BYTES-1:0]     wbe_i,
  input  logic                     re_i,
  input  logic [ADDRESS_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; zeroing is the clear sweep's job.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (we_i && wbe_i[i]) begin
        mem[waddr_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Word the read port would see if the concurrent write landed first.
  always_comb begin
    merged = mem[raddr_i];
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (we_i && wbe_i[i] && (waddr_i == raddr_i)) begin
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_i[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (RDW_MODE == RDW_WRITE_FIRST) ? merged : mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM top: clear sequencer, write-port mux, read-valid
// pipeline and the optional second output register for latency 2.
module bram_sdp
  import bram_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 6,
  parameter int DATA_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = RDW_WRITE_FIRST,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [NUM_BYTES-1:0]     wr_be,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     busy
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("bram_sdp: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("bram_sdp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  clr_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                     valid1_q;
  logic                     rd_acc;
  logic                     core_we;
  logic [ADDRESS_WIDTH-1:0] core_waddr;
  logic [DATA_WIDTH-1:0]    core_wdata;
  logic [NUM_BYTES-1:0]     core_wbe;
  logic [DATA_WIDTH-1:0]    core_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? CLR_SWEEP : CLR_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy       = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr) begin
          state_d    = CLR_SWEEP;
          clr_addr_d = '0;
        end
      end
      CLR_SWEEP: begin
        busy       = 1'b1;
        clr_addr_d = clr_addr_q + ADDRESS_WIDTH'(1);
        if (clr_addr_q == '1) state_d = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // The sweep owns the write port while busy; user traffic is dropped.
  assign rd_acc     = rd_en && !busy;
  assign core_we    = busy || wr_en;
  assign core_waddr = busy ? clr_addr_q : wr_addr;
  assign core_wdata = busy ? '0 : wr_data;
  assign core_wbe   = busy ? '1 : wr_be;

  bram_sdp_core #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .BYTE_WIDTH    (BYTE_WIDTH),
    .RDW_MODE      (RDW_MODE)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .we_i    (core_we),
    .waddr_i (core_waddr),
    .wdata_i (core_wdata),
    .wbe_i   (core_wbe),
    .re_i    (rd_acc),
    .raddr_i (rd_addr),
    .rdata_o (core_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid1_q <= 1'b0;
    else     valid1_q <= rd_acc;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  valid2_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q <= '0;
        valid2_q  <= 1'b0;
      end else begin
        valid2_q <= valid1_q;
        if (valid1_q) rd_data_q <= core_rdata;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = valid2_q;
  end else begin : g_lat1
    assign rd_data  = core_rdata;
    assign rd_valid = valid1_q;
  end

endmodule

// File: doc/bram_sdp.md
Name: bram_sdp

Overview:
- Parametrised simple-dual-port block RAM with independent write and read ports, both on `clk`.
- Successor to the single-port asynchronous-read RAM. Adds byte-enable writes, registered reads with a selectable latency of 1 or 2 cycles, and a read-valid pipeline.
- Read-during-write to the same address has a defined result, selected by parameter.
- A hardware clear sequencer zeroes the whole array after reset or on request.
- Used wherever the design needs packet or frame buffering with concurrent fill and drain.

Parameters:
- ADDRESS_WIDTH, 6, address bits; depth = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 8, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per byte-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1, 1 or 2 cycles from accepted read to rd_valid; other values are an elaboration error.
- RDW_MODE, 0, 0 = WRITE_FIRST, 1 = READ_FIRST.
- CLEAR_ON_RESET, 1, 1 = start clear sweep on reset release, 0 = come out of reset idle.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  request a full-array clear sweep (pulse).
- wr_en  input  1  write request.
- wr_addr  input  ADDRESS_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- wr_be  input  NUM_BYTES  byte enables; bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- rd_en  input  1  read request.
- rd_addr  input  ADDRESS_WIDTH  read address.
- rd_data  output  DATA_WIDTH  read data.
- rd_valid  output  1  rd_data holds the result of an accepted read this cycle.
- busy  output  1  clear sweep in progress.

Behaviour:
- Clocking and reset: single clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values of outputs and state:
  - rd_data = 0, rd_valid = 0, latency pipeline = 0.
  - FSM = CLEAR if CLEAR_ON_RESET, else IDLE; clear address = 0.
  - busy follows the FSM state.
  - Array contents are not reset; they are zeroed only by the sweep.
- Write acceptance: write is accepted when wr_en && !busy. At that edge, each lane with wr_be[i]=1 is updated; other lanes keep their contents. wr_be = 0 is a no-op.
- Read acceptance and timing: read is accepted when rd_en && !busy. If accepted at edge N, rd_data and rd_valid=1 appear after edge N+READ_LATENCY-1, i.e. in the cycle following edge N for latency 1, and one cycle later for latency 2.
  - Back-to-back reads give one result per cycle, in order.
  - When no result is due, rd_valid = 0 and rd_data holds its last value.
- Read-during-write (same edge, same address, both accepted):
  - WRITE_FIRST: returns the merged word (enabled lanes from wr_data, others from the array).
  - READ_FIRST: returns the pre-write contents.
  - Different addresses do not interact.
- FSM states:
  - IDLE: busy = 0. clr=1 → CLEAR at next edge, clear address = 0.
  - CLEAR: busy = 1. Each cycle writes 0 to the clear address and increments it. At clear address = 2**ADDRESS_WIDTH-1 that word is written and the FSM returns to IDLE. The sweep takes exactly 2**ADDRESS_WIDTH cycles with busy high.
- Boundary conditions:
  - clr asserted during CLEAR is ignored; the sweep does not restart.
  - wr_en or rd_en asserted while busy is dropped silently; no rd_valid is produced.
  - Reads accepted before busy rises still complete with their pre-clear data.
  - Reset mid-sweep or mid-read aborts everything: pipeline is flushed (rd_valid = 0) and the sweep restarts at address 0 if CLEAR_ON_RESET.
  - Address arithmetic wraps modulo depth; no out-of-range addresses exist.

Decomposition:
- Package bram_pkg:
  - constants RDW_WRITE_FIRST = 0 and RDW_READ_FIRST = 1.
  - enum clr_state_e {CLR_IDLE, CLR_SWEEP}.
- Sub-module bram_sdp_core:
  - bare array, no reset.
  - byte-enable write port; muxed between user write and clear write by the top.
  - synchronous read port implementing RDW_MODE.
- The top holds the FSM, the clear address counter, the valid pipeline and the optional second output register.

Test Plan:
All scenarios use ADDRESS_WIDTH=6, DATA_WIDTH=32, BYTE_WIDTH=8.
1. Clear on reset:
   - Stimulus: release rst, wait.
   - Response: busy high for exactly 64 cycles; then read addresses 0, 31 and 63 → rd_data 0x00000000, each with rd_valid.
2. Byte enables:
   - Stimulus: write 0xAABBCCDD to addr 5 with be=1111, then 0x11223344 with be=0101; read addr 5.
   - Response: 0xAABB_CC44 → 0xAA22CC44.
3. Latency:
   - Stimulus: READ_LATENCY=1 and 2; reads to addrs 1, 2, 3 on consecutive cycles.
   - Response: rd_valid asserted exactly 1 or 2 cycles later respectively, for three consecutive cycles, data in order.
4. Read-during-write:
   - Stimulus: addr 9 holds 0x12345678; same-cycle write 0xFFFFFFFF (be=0011) and read of addr 9.
   - Response: WRITE_FIRST → 0x1234FFFF; READ_FIRST → 0x12345678.
5. Clear while busy:
   - Stimulus: clr pulse; during the sweep pulse clr again and issue a write to addr 0 and a read.
   - Response: busy lasts 64 cycles from the first pulse; no rd_valid; addr 0 reads 0 afterwards.
6. Reset mid-sweep:
   - Stimulus: assert rst at sweep cycle 20 with a read in flight.
   - Response: rd_valid drops immediately; after release, busy high for a full 64 cycles.
